mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single external memory bus (address/data/RW) between the IMTC20 core and one
//  DMA/program-loader requester. Stalls the core through its CE input, and only at an
//  instruction boundary (step counter = 0). Bounds each DMA burst and enforces a minimum
//  CPU window between bursts. Sits between the core and external memory, above the core.
// PARAMETERS
//  D_WIDTH    8   data bus width
//  A_WIDTH    10  address bus width
//  LEN_W      8   width of DMA_LEN and the burst counter
//  MAX_BURST  16  max transfers per grant (1..2^LEN_W-1)
//  CPU_GAP    4   enabled CPU cycles required after a release before the next grant (>=1)
// PORTS
//  CLK        in   1        clock, rising edge
//  ARST       in   1        asynchronous reset, active-high
//  EN         in   1        global run enable
//  CPU_SYNC   in   1        1 when core step counter == 0 (instruction boundary)
//  CPU_ADDR   in   A_WIDTH  core address (MAR output)
//  CPU_RW     in   1        core RW; 1 = write
//  CPU_CE     out  1        clock enable to core; 0 = stalled
//  DMA_REQ    in   1        bus request, level; held high for the whole burst
//  DMA_LEN    in   LEN_W    requested transfers; sampled on grant
//  DMA_STB    in   1        one transfer this cycle (honoured only while DMA_GNT=1)
//  DMA_ADDR   in   A_WIDTH  DMA address
//  DMA_RW     in   1        DMA direction; 1 = write
//  DMA_GNT    out  1        bus owned by DMA
//  DMA_RVALID out  1        read data valid on MEM_RDATA (1 cycle after read strobe)
//  DMA_DONE   out  1        one-cycle pulse on release
//  MEM_ADDR   out  A_WIDTH  address to memory
//  MEM_RW     out  1        RW to memory and to data-bus tristate control
// BEHAVIOUR
//  Reset: state=CPU_OWN, DMA_GNT=0, DMA_DONE=0, DMA_RVALID=0, burst cnt=0, gap cnt=0.
//   CPU_CE=EN, MEM_RW=CPU_RW, MEM_ADDR=CPU_ADDR.
//  CPU_OWN:  CPU_CE=EN. MEM = CPU signals. Gap cnt decrements on cycles with CPU_CE=1.
//            DMA_REQ & EN & gap==0 -> DRAIN.
//  DRAIN:    MEM = CPU signals.
//            CPU_SYNC=0: CPU_CE=EN, stay.
//            CPU_SYNC=1: CPU_CE=0 in that same cycle (combinational), so the core holds at step 0.
//              Load cnt=min(DMA_LEN,MAX_BURST), then -> GRANT.
//            DMA_REQ dropped -> CPU_OWN, no grant.
//  GRANT:    CPU_CE=0, DMA_GNT=1. MEM_ADDR=DMA_ADDR. MEM_RW=DMA_RW&DMA_STB (idle = read).
//            DMA_STB: cnt--. Last transfer (cnt==1 & STB), cnt==0 on entry, or DMA_REQ=0 -> RELEASE.
//  RELEASE:  one cycle. CPU_CE=0, DMA_GNT=0, DMA_DONE=1, MEM = CPU signals, MEM_RW forced 0.
//            Gap cnt=CPU_GAP. -> CPU_OWN.
//  DMA_GNT and DMA_DONE are registered (decoded from the state register).
//   DMA_RVALID <= GRANT & DMA_STB & ~DMA_RW (memory read latency 1).
//  Write data path: not routed by this block. DMA_GNT selects the data-bus driver outside.
//  EN=0: no new grant from CPU_OWN. A burst already in progress completes normally. CPU_CE stays 0.
//  DMA_STB while DMA_GNT=0: ignored, no memory access.
//  DMA_LEN > MAX_BURST: truncated. The requester sees DMA_DONE, keeps DMA_REQ high,
//   and is regranted after the gap.
//  DMA_REQ and CPU_SYNC rising in the same cycle in CPU_OWN: DRAIN is entered.
//   The grant follows at the next CPU_SYNC=1.
//  ARST mid-burst: immediate return to the reset state. DMA_GNT drops asynchronously. No DMA_DONE pulse.
// STRUCTURE
//  bus_arb_defs.vh: state encodings (2-bit: CPU_OWN=0, DRAIN=1, GRANT=2, RELEASE=3), RW_WRITE=1.
//  Burst counter: existing Counter_reg, WIDTH=LEN_W, using LOAD and DEC.
//  Gap counter: existing Counter_reg, sized clog2(CPU_GAP+1).
//  FSM and output muxes are local to this module.
// TESTING
//  1. Idle bus, DMA_REQ=0 for 20 cycles
//     -> CPU_CE=1 every cycle, MEM_ADDR tracks CPU_ADDR, DMA_GNT=0.
//  2. DMA_REQ=1, DMA_LEN=3, CPU_SYNC high 2 cycles later
//     -> CPU_CE=0 in the SYNC cycle, DMA_GNT=1 next cycle.
//     -> Three STB writes to 0x100..0x102 show MEM_RW=1. DMA_DONE pulses 1 cycle after the 3rd.
//  3. DMA_LEN=40, MAX_BURST=16, DMA_REQ held
//     -> 16 transfers, DMA_DONE, then exactly 4 cycles with CPU_CE=1 before the next DRAIN.
//     -> 16+16+8 transfers in total.
//  4. Read strobe at address 0x2A5
//     -> MEM_RW=0, MEM_ADDR=0x2A5, DMA_RVALID=1 on the following cycle only.
//  5. ARST asserted on the 2nd of 5 transfers
//     -> DMA_GNT=0 without a clock edge, DMA_DONE stays 0.
//     -> CPU_CE=EN after ARST deasserts.
//  6. EN=0 with DMA_REQ=1 in CPU_OWN -> no grant and CPU_CE=0. Set EN=1 -> grant at the next CPU_SYNC.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM state encoding and bus direction constants.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_CPU_OWN = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the core, the DMA requester, external memory and the arbiter.
interface mem_bus_arbiter_if #(
    parameter int A_WIDTH = 10,
    parameter int LEN_W   = 8
);
    logic               EN;
    logic               CPU_SYNC;
    logic [A_WIDTH-1:0] CPU_ADDR;
    logic               CPU_RW;
    logic               CPU_CE;
    logic               DMA_REQ;
    logic [LEN_W-1:0]   DMA_LEN;
    logic               DMA_STB;
    logic [A_WIDTH-1:0] DMA_ADDR;
    logic               DMA_RW;
    logic               DMA_GNT;
    logic               DMA_RVALID;
    logic               DMA_DONE;
    logic [A_WIDTH-1:0] MEM_ADDR;
    logic               MEM_RW;

    // Requesters and core side
    modport master (
        output EN, CPU_SYNC, CPU_ADDR, CPU_RW, DMA_REQ, DMA_LEN, DMA_STB, DMA_ADDR, DMA_RW,
        input  CPU_CE, DMA_GNT, DMA_RVALID, DMA_DONE, MEM_ADDR, MEM_RW
    );

    // Arbiter side
    modport slave (
        input  EN, CPU_SYNC, CPU_ADDR, CPU_RW, DMA_REQ, DMA_LEN, DMA_STB, DMA_ADDR, DMA_RW,
        output CPU_CE, DMA_GNT, DMA_RVALID, DMA_DONE, MEM_ADDR, MEM_RW
    );

endinterface

// File: rtl/mem_bus_arbiter_counter.sv
// Loadable down-counter that saturates at zero; used for the burst length and the CPU gap window.
module mem_bus_arbiter_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external memory bus between the core and one DMA requester. The core is stalled
// only at an instruction boundary; bursts are length-bounded and separated by a CPU window.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int A_WIDTH   = 10,
    parameter int LEN_W     = 8,
    parameter int MAX_BURST = 16,
    parameter int CPU_GAP   = 4
) (
    input  logic             CLK,
    input  logic             ARST,
    mem_bus_arbiter_if.slave bus
);
    localparam int               GAP_W   = $clog2(CPU_GAP + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);
    localparam logic [GAP_W-1:0] GAP_LEN = GAP_W'(CPU_GAP);

    arb_state_e         state_d, state_q;
    logic               rvalid_d, rvalid_q;
    logic               burst_load, burst_dec, gap_load, gap_dec, gap_open;
    logic [LEN_W-1:0]   burst_cnt, burst_init;
    logic [GAP_W-1:0]   gap_cnt;
    logic               cpu_ce, mem_rw;
    logic [A_WIDTH-1:0] mem_addr;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    assign burst_init = clamp_len(bus.DMA_LEN);
    // The window is satisfied on the enabled cycle that consumes its last count, so exactly
    // CPU_GAP core cycles run between a release and the next drain.
    assign gap_open   = (gap_cnt == '0) || ((gap_cnt == GAP_W'(1)) && bus.EN);

    mem_bus_arbiter_counter #(.WIDTH(LEN_W)) u_burst_cnt (
        .clk(CLK), .rst(ARST), .load(burst_load), .dec(burst_dec),
        .load_val(burst_init), .count(burst_cnt)
    );

    mem_bus_arbiter_counter #(.WIDTH(GAP_W)) u_gap_cnt (
        .clk(CLK), .rst(ARST), .load(gap_load), .dec(gap_dec),
        .load_val(GAP_LEN), .count(gap_cnt)
    );

    always_comb begin
        state_d    = state_q;
        cpu_ce     = bus.EN;
        mem_addr   = bus.CPU_ADDR;
        mem_rw     = bus.CPU_RW;
        burst_load = 1'b0;
        burst_dec  = 1'b0;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;
        rvalid_d   = 1'b0;
        case (state_q)
            ST_CPU_OWN: begin
                gap_dec = bus.EN;
                if (bus.DMA_REQ && bus.EN && gap_open) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!bus.DMA_REQ) begin
                    state_d = ST_CPU_OWN;
                end else if (bus.CPU_SYNC) begin
                    // Freeze the core in this very cycle so it holds at step 0.
                    cpu_ce     = 1'b0;
                    burst_load = 1'b1;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                cpu_ce    = 1'b0;
                mem_addr  = bus.DMA_ADDR;
                mem_rw    = (bus.DMA_RW == RW_WRITE) && bus.DMA_STB;
                burst_dec = bus.DMA_STB && (burst_cnt != '0);
                rvalid_d  = bus.DMA_STB && (bus.DMA_RW != RW_WRITE);
                if (!bus.DMA_REQ || (burst_cnt == '0) ||
                    (bus.DMA_STB && (burst_cnt == LEN_W'(1)))) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                cpu_ce   = 1'b0;
                mem_rw   = RW_READ;
                gap_load = 1'b1;
                state_d  = ST_CPU_OWN;
            end
            default: state_d = ST_CPU_OWN;
        endcase
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            state_q  <= ST_CPU_OWN;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.CPU_CE     = cpu_ce;
    assign bus.MEM_ADDR   = mem_addr;
    assign bus.MEM_RW     = mem_rw;
    assign bus.DMA_GNT    = (state_q == ST_GRANT);
    assign bus.DMA_DONE   = (state_q == ST_RELEASE);
    assign bus.DMA_RVALID = rvalid_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: scripted vector table, multi-cycle corner
// sequences, and randomized traffic against a behavioural model of the arbitration rules.
module tb_mem_bus_arbiter;
    localparam int A_WIDTH   = 10;
    localparam int LEN_W     = 8;
    localparam int MAX_BURST = 16;
    localparam int CPU_GAP   = 4;

    typedef struct packed {
        logic               ce;
        logic               gnt;
        logic               done;
        logic               rv;
        logic [A_WIDTH-1:0] maddr;
        logic               mrw;
    } out_t;

    typedef struct packed {
        logic               en;
        logic               sync;
        logic               req;
        logic [LEN_W-1:0]   len;
        logic               stb;
        logic [A_WIDTH-1:0] daddr;
        logic               drw;
        logic [A_WIDTH-1:0] caddr;
        logic               crw;
        out_t               exp;
    } vec_t;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    // Behavioural model: who owns the bus, what is left of the burst, how long the core window runs.
    bit m_waiting, m_dma, m_releasing, m_rv;
    int m_left, m_cool;

    mem_bus_arbiter_if #(.A_WIDTH(A_WIDTH), .LEN_W(LEN_W)) bus ();

    mem_bus_arbiter #(
        .A_WIDTH(A_WIDTH), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST), .CPU_GAP(CPU_GAP)
    ) dut (
        .CLK(clk), .ARST(arst), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t V(input int en, sync, req, len, stb, daddr, drw, caddr, crw,
                               ce, gnt, done, rv, maddr, mrw);
        vec_t v;
        v.en        = (en != 0);
        v.sync      = (sync != 0);
        v.req       = (req != 0);
        v.len       = LEN_W'(len);
        v.stb       = (stb != 0);
        v.daddr     = A_WIDTH'(daddr);
        v.drw       = (drw != 0);
        v.caddr     = A_WIDTH'(caddr);
        v.crw       = (crw != 0);
        v.exp.ce    = (ce != 0);
        v.exp.gnt   = (gnt != 0);
        v.exp.done  = (done != 0);
        v.exp.rv    = (rv != 0);
        v.exp.maddr = A_WIDTH'(maddr);
        v.exp.mrw   = (mrw != 0);
        return v;
    endfunction

    task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input out_t exp);
        chk_v({tag, " CPU_CE"},     32'(bus.CPU_CE),     32'(exp.ce));
        chk_v({tag, " DMA_GNT"},    32'(bus.DMA_GNT),    32'(exp.gnt));
        chk_v({tag, " DMA_DONE"},   32'(bus.DMA_DONE),   32'(exp.done));
        chk_v({tag, " DMA_RVALID"}, 32'(bus.DMA_RVALID), 32'(exp.rv));
        chk_v({tag, " MEM_ADDR"},   32'(bus.MEM_ADDR),   32'(exp.maddr));
        chk_v({tag, " MEM_RW"},     32'(bus.MEM_RW),     32'(exp.mrw));
    endtask

    task automatic drive(input vec_t v);
        bus.EN       = v.en;
        bus.CPU_SYNC = v.sync;
        bus.DMA_REQ  = v.req;
        bus.DMA_LEN  = v.len;
        bus.DMA_STB  = v.stb;
        bus.DMA_ADDR = v.daddr;
        bus.DMA_RW   = v.drw;
        bus.CPU_ADDR = v.caddr;
        bus.CPU_RW   = v.crw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input string tag, input vec_t v);
        drive(v);
        @(negedge clk);
        chk_out(tag, v.exp);
        step();
    endtask

    task automatic model_reset();
        m_waiting   = 1'b0;
        m_dma       = 1'b0;
        m_releasing = 1'b0;
        m_rv        = 1'b0;
        m_left      = 0;
        m_cool      = 0;
    endtask

    task automatic do_reset();
        vec_t v;
        arst = 1'b1;
        v = V(1, 0, 0, 0, 0, 'h3C3, 0, 'h155, 1, 1, 0, 0, 0, 'h155, 1);
        drive(v);
        @(negedge clk);
        chk_out("reset", v.exp);
        step();
        arst = 1'b0;
        model_reset();
    endtask

    function automatic out_t model_out();
        out_t o;
        o.gnt  = m_dma;
        o.done = m_releasing;
        o.rv   = m_rv;
        if (m_dma || m_releasing || (m_waiting && bus.DMA_REQ && bus.CPU_SYNC)) o.ce = 1'b0;
        else o.ce = bus.EN;
        o.maddr = m_dma ? bus.DMA_ADDR : bus.CPU_ADDR;
        if (m_dma) o.mrw = bus.DMA_RW & bus.DMA_STB;
        else if (m_releasing) o.mrw = 1'b0;
        else o.mrw = bus.CPU_RW;
        return o;
    endfunction

    task automatic model_step();
        bit finish;
        bit rv_next;
        rv_next = m_dma && bus.DMA_STB && !bus.DMA_RW;
        if (m_releasing) begin
            m_releasing = 1'b0;
            m_cool      = CPU_GAP;
        end else if (m_dma) begin
            finish = !bus.DMA_REQ || (m_left == 0) || (bus.DMA_STB && (m_left == 1));
            if (bus.DMA_STB && (m_left > 0)) m_left--;
            if (finish) begin
                m_dma       = 1'b0;
                m_releasing = 1'b1;
            end
        end else if (m_waiting) begin
            if (!bus.DMA_REQ) begin
                m_waiting = 1'b0;
            end else if (bus.CPU_SYNC) begin
                m_waiting = 1'b0;
                m_dma     = 1'b1;
                m_left    = (int'(bus.DMA_LEN) > MAX_BURST) ? MAX_BURST : int'(bus.DMA_LEN);
            end
        end else begin
            if (bus.EN && (m_cool > 0)) m_cool--;
            if (bus.DMA_REQ && bus.EN && (m_cool == 0)) m_waiting = 1'b1;
        end
        m_rv = rv_next;
    endtask

    initial begin
        vec_t tbl[16];
        vec_t v;
        out_t e;
        int   remaining, cur, nb, ng, ce_run, n_g;
        bit   in_gap, req_r;
        int   sizes[3];
        int   gaps[2];

        //        en sy rq len stb daddr  drw caddr  crw | ce gnt dn rv maddr  mrw
        tbl[0]  = V(1, 0, 0, 0, 0, 'h000, 0, 'h011, 0,   1, 0, 0, 0, 'h011, 0);
        tbl[1]  = V(1, 0, 1, 3, 0, 'h100, 1, 'h012, 0,   1, 0, 0, 0, 'h012, 0);
        tbl[2]  = V(1, 0, 1, 3, 0, 'h100, 1, 'h013, 1,   1, 0, 0, 0, 'h013, 1);
        tbl[3]  = V(1, 1, 1, 3, 0, 'h100, 1, 'h014, 0,   0, 0, 0, 0, 'h014, 0);
        tbl[4]  = V(1, 0, 1, 3, 1, 'h100, 1, 'h014, 0,   0, 1, 0, 0, 'h100, 1);
        tbl[5]  = V(1, 1, 1, 3, 1, 'h101, 1, 'h014, 0,   0, 1, 0, 0, 'h101, 1);
        tbl[6]  = V(1, 0, 1, 3, 1, 'h102, 1, 'h014, 0,   0, 1, 0, 0, 'h102, 1);
        tbl[7]  = V(1, 0, 0, 0, 0, 'h102, 1, 'h014, 1,   0, 0, 1, 0, 'h014, 0);
        tbl[8]  = V(1, 0, 1, 1, 0, 'h000, 0, 'h020, 1,   1, 0, 0, 0, 'h020, 1);
        tbl[9]  = V(1, 0, 1, 1, 1, 'h3FF, 1, 'h021, 0,   1, 0, 0, 0, 'h021, 0);
        tbl[10] = V(1, 1, 1, 1, 0, 'h000, 0, 'h022, 0,   1, 0, 0, 0, 'h022, 0);
        tbl[11] = V(1, 0, 1, 1, 0, 'h000, 0, 'h023, 0,   1, 0, 0, 0, 'h023, 0);
        tbl[12] = V(1, 1, 1, 1, 0, 'h000, 0, 'h024, 0,   0, 0, 0, 0, 'h024, 0);
        tbl[13] = V(1, 0, 1, 1, 1, 'h2A5, 0, 'h024, 0,   0, 1, 0, 0, 'h2A5, 0);
        tbl[14] = V(1, 0, 0, 0, 0, 'h2A5, 0, 'h024, 0,   0, 0, 1, 1, 'h024, 0);
        tbl[15] = V(1, 0, 0, 0, 0, 'h000, 0, 'h025, 0,   1, 0, 0, 0, 'h025, 0);

        do_reset();
        for (int i = 0; i < 16; i++) apply($sformatf("tbl%0d", i), tbl[i]);

        // Idle bus: the core runs every cycle and owns the address bus.
        for (int i = 0; i < 20; i++)
            apply($sformatf("idle%0d", i), V(1, i % 2, 0, 0, i % 3, 'h3FF, 1, 'h040 + i, i % 2,
                                             1, 0, 0, 0, 'h040 + i, i % 2));

        // Oversized request: bursts are truncated and a full core window separates them.
        do_reset();
        remaining = 40; cur = 0; nb = 0; ng = 0; ce_run = 0; in_gap = 1'b0;
        for (int c = 0; c < 300 && nb < 3; c++) begin
            drive(V(1, 1, (remaining > 0) ? 1 : 0, remaining, 1, 'h050, 1, 'h033, 0,
                    0, 0, 0, 0, 0, 0));
            @(negedge clk);
            if (bus.DMA_GNT === 1'b1) begin
                if (in_gap) begin
                    if (ng < 2) gaps[ng] = ce_run;
                    ng++;
                    in_gap = 1'b0;
                end
                cur++;
                if (remaining > 0) remaining--;
            end else if (in_gap && (bus.CPU_CE === 1'b1)) begin
                ce_run++;
            end
            if (bus.DMA_DONE === 1'b1) begin
                if (nb < 3) sizes[nb] = cur;
                nb++;
                cur    = 0;
                in_gap = 1'b1;
                ce_run = 0;
            end
            step();
        end
        chk_v("trunc bursts", 32'(nb), 32'd3);
        chk_v("trunc burst0", 32'(sizes[0]), 32'd16);
        chk_v("trunc burst1", 32'(sizes[1]), 32'd16);
        chk_v("trunc burst2", 32'(sizes[2]), 32'd8);
        chk_v("trunc gaps", 32'(ng), 32'd2);
        chk_v("trunc gap0", 32'(gaps[0]), 32'(CPU_GAP));
        chk_v("trunc gap1", 32'(gaps[1]), 32'(CPU_GAP));
        chk_v("trunc total", 32'(40 - remaining), 32'd40);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        n_g = 0;
        for (int c = 0; c < 20 && n_g < 2; c++) begin
            drive(V(1, 1, 1, 5, 1, 'h0AA, 1, 'h044, 0, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            if (bus.DMA_GNT === 1'b1) n_g++;
            if (n_g < 2) step();
        end
        chk_v("arst 2nd xfer reached", 32'(n_g), 32'd2);
        arst = 1'b1;
        #1;
        chk_v("arst DMA_GNT async", 32'(bus.DMA_GNT), 32'd0);
        chk_v("arst DMA_DONE", 32'(bus.DMA_DONE), 32'd0);
        chk_v("arst CPU_CE", 32'(bus.CPU_CE), 32'd1);
        step();
        arst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++)
            apply($sformatf("post_arst%0d", i), V(1, 0, 0, 0, 0, 'h0AA, 1, 'h045, 0,
                                                  1, 0, 0, 0, 'h045, 0));

        // EN=0 holds off a pending request; grant follows the next boundary once enabled.
        do_reset();
        for (int i = 0; i < 6; i++)
            apply($sformatf("en0_%0d", i), V(0, i % 2, 1, 2, 0, 'h1F0, 0, 'h060 + i, 0,
                                              0, 0, 0, 0, 'h060 + i, 0));
        apply("en1_own",   V(1, 0, 1, 2, 0, 'h1F0, 0, 'h070, 0, 1, 0, 0, 0, 'h070, 0));
        apply("en1_drain", V(1, 0, 1, 2, 0, 'h1F0, 0, 'h071, 0, 1, 0, 0, 0, 'h071, 0));
        apply("en1_sync",  V(1, 1, 1, 2, 0, 'h1F0, 0, 'h072, 0, 0, 0, 0, 0, 'h072, 0));
        apply("en1_grant", V(1, 0, 0, 2, 0, 'h1F0, 1, 'h072, 1, 0, 1, 0, 0, 'h1F0, 0));
        apply("en1_rel",   V(1, 0, 0, 0, 0, 'h1F0, 0, 'h073, 1, 0, 0, 1, 0, 'h073, 0));
        apply("en1_back",  V(1, 0, 0, 0, 0, 'h1F0, 0, 'h074, 1, 1, 0, 0, 0, 'h074, 1));

        // Randomized traffic against the behavioural model.
        do_reset();
        req_r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) req_r = !req_r;
            v = V(int'($urandom_range(0, 9) != 0), int'($urandom_range(0, 2) == 0), int'(req_r),
                  int'($urandom_range(0, 40)), int'($urandom_range(0, 4) < 3),
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)),
                  0, 0, 0, 0, 0, 0);
            drive(v);
            e = model_out();
            @(negedge clk);
            chk_out($sformatf("rnd%0d", c), e);
            model_step();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
